// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pkg
//  Description : Shared SHA-256 constants (round constants, IV, padding words),
//                the bit-level helper functions and the controller state enum
//                for the double-SHA-256 nonce engine.
//  Revision    : 1.0  initial release
// ============================================================================
package sha256_pkg;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // Padding: leading '1' bit, then message length in bits for each block.
   localparam logic [31:0] PAD_WORD   = 32'h80000000;
   localparam logic [31:0] LEN_BLOCK2 = 32'd640;
   localparam logic [31:0] LEN_HASH2  = 32'd256;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ROUND1 = 3'd2,
      ST_FIN1   = 3'd3,
      ST_ROUND2 = 3'd4,
      ST_FIN2   = 3'd5
   } state_e;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] Sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] Sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                      input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage
`default_nettype wire

// File: rtl/computer_if.sv
`default_nettype none
// ============================================================================
//  Module      : computer_if
//  Description : Host-side bus of the nonce engine: midstate, header words,
//                start request, completion pulse and per-nonce results.
//  Revision    : 1.0  initial release
// ============================================================================
interface computer_if #(
   parameter int N = 15
);
   logic [31:0] h       [0:7];
   logic [31:0] pass    [0:2];
   logic        start;
   logic        done;
   logic [31:0] answers [0:N];

   modport master (output h, output pass, output start, input done, input answers);
   modport slave  (input h, input pass, input start, output done, output answers);
endinterface
`default_nettype wire

// File: rtl/sha256_round_core.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_round_core
//  Description : One per-nonce SHA-256 datapath: working registers A..H and a
//                16-word rolling message schedule. The schedule window doubles
//                as the D1 holding register once hash 1 finishes, since the
//                hash-2 block is exactly D1 plus constant padding.
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_round_core
   import sha256_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        round,
   input  logic        finish,
   input  logic [31:0] k,
   input  logic [31:0] nonce,
   input  logic [31:0] h     [0:7],
   input  logic [31:0] pass  [0:2],
   output logic [31:0] a_out
);

   logic [31:0] wk_q [0:7];
   logic [31:0] wk_d [0:7];
   logic [31:0] w_q  [0:15];
   logic [31:0] w_d  [0:15];
   logic [31:0] t1;
   logic [31:0] t2;
   logic [31:0] w_next;

   // Next working/schedule state for load, one round, or hash-1 finalisation.
   always_comb begin
      wk_d   = wk_q;
      w_d    = w_q;
      t1     = wk_q[7] + Sigma1(wk_q[4]) + ch(wk_q[4], wk_q[5], wk_q[6]) + k + w_q[0];
      t2     = Sigma0(wk_q[0]) + maj(wk_q[0], wk_q[1], wk_q[2]);
      w_next = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];
      if (load) begin
         wk_d = h;
         for (int j = 0; j < 16; j++) w_d[j] = '0;
         w_d[0]  = pass[0];
         w_d[1]  = pass[1];
         w_d[2]  = pass[2];
         w_d[3]  = nonce;
         w_d[4]  = PAD_WORD;
         w_d[15] = LEN_BLOCK2;
      end else if (round) begin
         wk_d[0] = t1 + t2;
         wk_d[1] = wk_q[0];
         wk_d[2] = wk_q[1];
         wk_d[3] = wk_q[2];
         wk_d[4] = wk_q[3] + t1;
         wk_d[5] = wk_q[4];
         wk_d[6] = wk_q[5];
         wk_d[7] = wk_q[6];
         for (int j = 0; j < 15; j++) w_d[j] = w_q[j + 1];
         w_d[15] = w_next;
      end else if (finish) begin
         for (int j = 0; j < 16; j++) w_d[j] = '0;
         for (int j = 0; j < 8; j++) w_d[j] = h[j] + wk_q[j];
         w_d[8]  = PAD_WORD;
         w_d[15] = LEN_HASH2;
         wk_d    = IV;
      end
   end

   // Datapath registers, cleared on reset so an aborted job leaves no residue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < 8; j++)  wk_q[j] <= '0;
         for (int j = 0; j < 16; j++) w_q[j]  <= '0;
      end else begin
         wk_q <= wk_d;
         w_q  <= w_d;
      end
   end

   assign a_out = wk_q[0];

endmodule
`default_nettype wire

// File: rtl/computer.sv
`default_nettype none
// ============================================================================
//  Module      : computer
//  Description : Parallel double-SHA-256 nonce engine. N+1 cores share one
//                controller and round counter; answers[i] is H0 of
//                SHA-256(SHA-256(header)) for nonce i. Latency 132 cycles.
//                Optional macro COMPUTER_ASSERT_EN compiles in SVA checks.
//  Revision    : 1.0  initial release
// ============================================================================
module computer
   import sha256_pkg::*;
#(
   parameter int N = 15
) (
   input  logic [31:0] h       [0:7],
   input  logic        reset,
   input  logic        clk,
   input  logic        start,
   output logic        done,
   output logic [31:0] answers [0:N],
   input  logic [31:0] pass    [0:2]
);

   state_e      state_q;
   state_e      state_d;
   logic [5:0]  t_q;
   logic [5:0]  t_d;
   logic        done_q;
   logic        done_d;
   logic        load;
   logic        round;
   logic        finish;
   logic        capture;
   logic [31:0] k_cur;

   assign k_cur = K[t_q];

   // Controller next-state and strobes; counter wraps to 0 after t=63.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      done_d  = 1'b0;
      load    = 1'b0;
      round   = 1'b0;
      finish  = 1'b0;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            load    = 1'b1;
            t_d     = '0;
            state_d = ST_ROUND1;
         end
         ST_ROUND1: begin
            round = 1'b1;
            t_d   = t_q + 6'd1;
            if (t_q == 6'd63) state_d = ST_FIN1;
         end
         ST_FIN1: begin
            finish  = 1'b1;
            state_d = ST_ROUND2;
         end
         ST_ROUND2: begin
            round = 1'b1;
            t_d   = t_q + 6'd1;
            if (t_q == 6'd63) state_d = ST_FIN2;
         end
         ST_FIN2: begin
            capture = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Controller registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         t_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         done_q  <= done_d;
      end
   end

   assign done = done_q;

   generate
      for (genvar i = 0; i <= N; i++) begin : g_core
         logic [31:0] a_fin;
         logic [31:0] answer_q;
         logic [31:0] answer_d;

         sha256_round_core u_core (
            .clk    (clk),
            .reset  (reset),
            .load   (load),
            .round  (round),
            .finish (finish),
            .k      (k_cur),
            .nonce  (32'(i)),
            .h      (h),
            .pass   (pass),
            .a_out  (a_fin)
         );

         // Result holds until the next completed job.
         always_comb begin
            answer_d = answer_q;
            if (capture) answer_d = IV[0] + a_fin;
         end

         // Result register for this nonce.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) answer_q <= '0;
            else       answer_q <= answer_d;
         end

         assign answers[i] = answer_q;
      end
   endgenerate

`ifdef COMPUTER_ASSERT_EN
   logic [255:0] h_flat;
   logic [95:0]  pass_flat;
   logic         busy;

   always_comb begin
      h_flat    = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
      pass_flat = {pass[0], pass[1], pass[2]};
   end

   assign busy = (state_q != ST_IDLE);

   a_done_single: assert property (@(posedge clk) disable iff (reset) done_q |=> !done_q);
   a_start_idle:  assert property (@(posedge clk) disable iff (reset) start |-> !busy)
      else $warning("start requested while engine busy; ignored");
   a_h_stable:    assert property (@(posedge clk) disable iff (reset)
                                   (busy && $past(busy)) |-> $stable(h_flat));
   a_pass_stable: assert property (@(posedge clk) disable iff (reset)
                                   (busy && $past(busy)) |-> $stable(pass_flat));
   a_t_range:     assert property (@(posedge clk) disable iff (reset) t_q <= 6'd63);
`endif

endmodule
`default_nettype wire

// File: tb/tb_computer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_computer
//  Description : Self-checking bench for the nonce engine against a plain
//                software double-SHA-256 model (full 64-word schedule).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_computer;

   typedef logic [31:0] w8_t  [8];
   typedef logic [31:0] w16_t [16];

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam w8_t IVT = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   logic        clk = 1'b0;
   logic        reset;
   logic        start_in;
   w8_t         h_in;
   logic [31:0] pass_in [0:2];
   logic [31:0] exp_ans [16];
   logic [31:0] old_ans [16];
   int          tests = 0;
   int          fails = 0;

   computer_if #(.N(15)) bus  ();
   computer_if #(.N(3))  bus3 ();

   assign bus.h      = h_in;
   assign bus.pass   = pass_in;
   assign bus.start  = start_in;
   assign bus3.h     = h_in;
   assign bus3.pass  = pass_in;
   assign bus3.start = start_in;

   computer #(.N(15)) dut (
      .h(bus.h), .reset(reset), .clk(clk), .start(bus.start),
      .done(bus.done), .answers(bus.answers), .pass(bus.pass)
   );

   computer #(.N(3)) dut3 (
      .h(bus3.h), .reset(reset), .clk(clk), .start(bus3.start),
      .done(bus3.done), .answers(bus3.answers), .pass(bus3.pass)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook SHA-256 compression of one block onto a chaining state.
   function automatic w8_t compress(input w8_t st, input w16_t m);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] s0, s1, t1, t2;
      w8_t r;
      for (int t = 0; t < 16; t++) w[t] = m[t];
      for (int t = 16; t < 64; t++) begin
         s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      v = st;
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
              + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
              + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int j = 0; j < 8; j++) r[j] = st[j] + v[j];
      return r;
   endfunction

   // H0 of SHA-256(SHA-256(header)) for one nonce, header = midstate + 3 words.
   function automatic logic [31:0] ref_h0(input int nonce);
      w16_t m;
      w8_t  d1, d2;
      for (int j = 0; j < 16; j++) m[j] = '0;
      m[0] = pass_in[0]; m[1] = pass_in[1]; m[2] = pass_in[2];
      m[3] = 32'(nonce); m[4] = 32'h80000000; m[15] = 32'd640;
      d1 = compress(h_in, m);
      for (int j = 0; j < 16; j++) m[j] = '0;
      for (int j = 0; j < 8; j++) m[j] = d1[j];
      m[8] = 32'h80000000; m[15] = 32'd256;
      d2 = compress(IVT, m);
      return d2[0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic compute_expected();
      for (int i = 0; i < 16; i++) exp_ans[i] = ref_h0(i);
   endtask

   task automatic check_answers(input string tag, input bit with_small);
      for (int i = 0; i < 16; i++) chk($sformatf("%s ans[%0d]", tag, i), bus.answers[i], exp_ans[i]);
      if (with_small)
         for (int i = 0; i < 4; i++) chk($sformatf("%s n3 ans[%0d]", tag, i), bus3.answers[i], exp_ans[i]);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, " done"}, 32'(bus.done), 32'd0);
      for (int i = 0; i < 16; i++) chk($sformatf("%s zero[%0d]", tag, i), bus.answers[i], 32'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("%s n3 zero[%0d]", tag, i), bus3.answers[i], 32'd0);
   endtask

   // Pulse start, then wait (bounded) for done. p1/p2: extra start pulses at
   // those cycle counts; hold_chk compares answers against old_ans meanwhile.
   task automatic run_job(input string tag, input int p1, input int p2, input bit hold_chk);
      int cyc;
      bit seen;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 300) begin
         tick();
         cyc++;
         start_in = (cyc == p1 || cyc == p2);
         if (hold_chk && (cyc == 1 || cyc == 64 || cyc == 130))
            chk($sformatf("%s hold@%0d", tag, cyc), bus.answers[5], old_ans[5]);
         if (bus.done) seen = 1'b1;
      end
      start_in = 1'b0;
      chk({tag, " latency"}, 32'(cyc), 32'd131);
   endtask

   initial begin
      int ndone;
      reset    = 1'b1;
      start_in = 1'b1;
      h_in     = IVT;
      for (int j = 0; j < 3; j++) pass_in[j] = '0;
      repeat (5) tick();
      check_cleared("reset");
      start_in = 1'b0;
      reset    = 1'b0;
      repeat (2) tick();
      chk("idle done", 32'(bus.done), 32'd0);

      // Golden job: IV midstate, fixed header words.
      h_in = IVT;
      pass_in[0] = 32'h01234567; pass_in[1] = 32'h89abcdef; pass_in[2] = 32'hdeadbeef;
      compute_expected();
      run_job("golden", -1, -1, 1'b0);
      check_answers("golden", 1'b1);
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++) begin
            tests++;
            assert (bus3.answers[i] !== bus3.answers[j]) else begin
               fails++;
               $error("FAIL distinct[%0d,%0d] observed=%h expected=not %h", i, j,
                      bus3.answers[i], bus3.answers[j]);
            end
         end

      // Back-to-back: restart in the done cycle with zero header words.
      for (int i = 0; i < 16; i++) old_ans[i] = exp_ans[i];
      pass_in[0] = '0; pass_in[1] = '0; pass_in[2] = '0;
      compute_expected();
      run_job("b2b", -1, -1, 1'b1);
      check_answers("b2b", 1'b0);
      tick();
      chk("b2b done width", 32'(bus.done), 32'd0);

      // Busy start pulses at cycles 10 and 70 must be ignored.
      for (int j = 0; j < 8; j++) h_in[j] = $urandom();
      for (int j = 0; j < 3; j++) pass_in[j] = $urandom();
      compute_expected();
      run_job("busy", 10, 70, 1'b0);
      check_answers("busy", 1'b1);
      ndone = 0;
      for (int c = 0; c < 150; c++) begin
         tick();
         if (bus.done) ndone++;
      end
      chk("busy extra done", 32'(ndone), 32'd0);

      // Random jobs.
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 8; j++) h_in[j] = $urandom();
         for (int j = 0; j < 3; j++) pass_in[j] = $urandom();
         compute_expected();
         run_job($sformatf("rand%0d", r), -1, -1, 1'b0);
         check_answers($sformatf("rand%0d", r), 1'b1);
      end

      // Mid-run abort at cycle 50, then a fresh job.
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      repeat (50) tick();
      reset = 1'b1;
      #1;
      check_cleared("abort");
      tick();
      reset = 1'b0;
      ndone = 0;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (bus.done || bus3.done) ndone++;
      end
      chk("abort no done", 32'(ndone), 32'd0);
      chk("abort hold zero", bus.answers[0], 32'd0);
      for (int j = 0; j < 8; j++) h_in[j] = $urandom();
      for (int j = 0; j < 3; j++) pass_in[j] = $urandom();
      compute_expected();
      run_job("post-abort", -1, -1, 1'b0);
      check_answers("post-abort", 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
